// File: rtl/seq_pkg.sv
// Shared constants and types for the sequence-detector serial path.
package seq_pkg;

    localparam int SEQ_W = 12;
    localparam logic [SEQ_W-1:0] SEQ_PATTERN = 12'hEDB;

    typedef enum logic {
        SER_IDLE,
        SER_SHIFT
    } ser_state_e;

endpackage

// File: rtl/seq_serializer_if.sv
// Word handshake plus serial output bundle between upstream, serializer and detector.
interface seq_serializer_if #(
    parameter int W = 12
) ();

    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic         x_o;
    logic         x_valid_o;
    logic         last_o;
    logic         busy_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, x_o, x_valid_o, last_o, busy_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, x_o, x_valid_o, last_o, busy_o
    );

endinterface

// File: rtl/seq_serializer.sv
// Double-buffered parallel-to-serial front end: one active shift word plus one
// pending word so back-to-back words stream without an idle bit.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// SER_IDLE  | no active word, x_o held at IDLE_BIT
// SER_SHIFT | shift_q head on x_o, cnt_q counts bits already sent
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   W         = SEQ_W,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    seq_serializer_if.slave  bus
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    ser_state_e   state_q, state_d;
    logic [W-1:0] shift_q, shift_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pend_full_q, pend_full_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic         accept;
    logic         at_last;
    logic         head_bit;
    logic [W-1:0] shifted;

    assign bus.ready_o = !pend_full_q && !reset;
    assign accept      = bus.valid_i && bus.ready_o;
    assign at_last     = (cnt_q == CNT_LAST);

    // Head and advance direction depend only on the bit-order parameter.
    always_comb begin
        if (MSB_FIRST) begin
            head_bit = shift_q[W-1];
            shifted  = {shift_q[W-2:0], 1'b0};
        end else begin
            head_bit = shift_q[0];
            shifted  = {1'b0, shift_q[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SER_IDLE;
            shift_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cnt_d       = cnt_q;

        case (state_q)
            SER_IDLE: begin
                if (accept) begin
                    shift_d = bus.data_i;
                    cnt_d   = '0;
                    state_d = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (at_last) begin
                    cnt_d = '0;
                    // Pending word wins; ready_o is low so no accept can collide.
                    if (pend_full_q) begin
                        shift_d     = pend_q;
                        pend_full_d = 1'b0;
                    end else if (accept) begin
                        shift_d = bus.data_i;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end else begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (accept) begin
                        pend_d      = bus.data_i;
                        pend_full_d = 1'b1;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    assign bus.x_valid_o = (state_q == SER_SHIFT);
    assign bus.x_o       = bus.x_valid_o ? head_bit : IDLE_BIT;
    assign bus.last_o    = bus.x_valid_o && at_last;
    assign bus.busy_o    = bus.x_valid_o || pend_full_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share stimulus and
// are checked every cycle against a word-queue model of the serial stream.
module tb_seq_serializer;
    import seq_pkg::*;

    localparam int W = SEQ_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         v;
    logic [W-1:0] d;

    seq_serializer_if #(.W(W)) bus0 ();
    seq_serializer_if #(.W(W)) bus1 ();

    assign bus0.valid_i = v;
    assign bus0.data_i  = d;
    assign bus1.valid_i = v;
    assign bus1.data_i  = d;

    seq_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    seq_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    endtask

    // Model: queue of words accepted but not fully sent; pos = bits of head already sent.
    logic [W-1:0] mq[$];
    int           pos = 0;
    logic [W-1:0] offers[$];

    bit           cap_en = 1'b0;
    logic [W-1:0] cap0, cap1;

    task automatic step(input bit vi, input logic [W-1:0] di, input bit ri, output bit acc);
        bit   e_xv, e_last, e_ready;
        logic e_x0, e_x1;
        @(negedge clk);
        v     = vi;
        d     = di;
        reset = ri;
        #1;
        e_xv    = (mq.size() > 0);
        e_x0    = e_xv ? mq[0][W-1-pos] : 1'b0;
        e_x1    = e_xv ? mq[0][pos]     : 1'b0;
        e_last  = e_xv && (pos == W-1);
        e_ready = !ri && (mq.size() < 2);
        check("msb_xvalid", 32'(bus0.x_valid_o), 32'(e_xv));
        check("msb_x",      32'(bus0.x_o),       32'(e_x0));
        check("msb_last",   32'(bus0.last_o),    32'(e_last));
        check("msb_busy",   32'(bus0.busy_o),    32'(e_xv));
        check("msb_ready",  32'(bus0.ready_o),   32'(e_ready));
        check("lsb_xvalid", 32'(bus1.x_valid_o), 32'(e_xv));
        check("lsb_x",      32'(bus1.x_o),       32'(e_x1));
        check("lsb_last",   32'(bus1.last_o),    32'(e_last));
        check("lsb_ready",  32'(bus1.ready_o),   32'(e_ready));
        if (cap_en && bus0.x_valid_o) cap0 = {cap0[W-2:0], bus0.x_o};
        if (cap_en && bus1.x_valid_o) cap1 = {cap1[W-2:0], bus1.x_o};
        acc = vi && e_ready;
        @(posedge clk);
        if (ri) begin
            mq.delete();
            pos = 0;
        end else begin
            if (mq.size() > 0) begin
                pos++;
                if (pos == W) begin
                    void'(mq.pop_front());
                    pos = 0;
                end
            end
            if (acc) mq.push_back(di);
        end
    endtask

    task automatic feed(input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++) begin
            if (offers.size() > 0) step(1'b1, offers[0], 1'b0, acc);
            else step(1'b0, W'($urandom), 1'b0, acc);
            if (acc) void'(offers.pop_front());
        end
    endtask

    initial begin
        bit           acc;
        bit           rv;
        logic [W-1:0] rd;
        reset = 1'b1;
        v     = 1'b0;
        d     = '0;

        step(1'b0, '0, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        feed(2);

        // single word, captured bit streams in both orders
        cap_en = 1'b1;
        cap0 = '0;
        cap1 = '0;
        offers.push_back(SEQ_PATTERN);
        feed(16);
        cap_en = 1'b0;
        check("single_msb_bits", 32'(cap0), 32'(12'hEDB));
        check("single_lsb_bits", 32'(cap1), 32'(12'hDB7));

        // back-to-back: second word offered three cycles later
        offers.push_back(SEQ_PATTERN);
        feed(3);
        offers.push_back(12'h5A5);
        feed(30);

        // backpressure: three words offered continuously
        offers.push_back(12'hABC);
        offers.push_back(12'h123);
        offers.push_back(12'hF0F);
        feed(45);
        check("bp_drained", 32'(offers.size()), 32'd0);

        // reset mid-word with a pending word
        offers.push_back(SEQ_PATTERN);
        feed(1);
        offers.push_back(12'h5A5);
        feed(5);
        offers.delete();
        step(1'b0, '0, 1'b1, acc);
        feed(15);

        // randomized traffic with hold-while-stalled and occasional reset
        rv = 1'b0;
        rd = '0;
        acc = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit ri;
            if (!(rv && !acc)) begin
                rv = ($urandom_range(0, 99) < 70);
                rd = W'($urandom);
            end
            ri = ($urandom_range(0, 499) == 0);
            step(rv, rd, ri, acc);
            if (ri) acc = 1'b1;
        end
        feed(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
